melody_sequencer: RTL

Multi-voice square-wave melody player: it steps through a synchronous note ROM at a programmable tempo and generates one square wave per voice from the ROM half-period words. It mixes the voices into a single signed 32-bit sample for the audio controller's left/right outputs. It supersedes the single-voice, fixed-tempo tone generator in the audio top level and adds:
- N voices
- start/pause/loop control
- rests
- a saturating mixer
- a compile-time tempo-change feature

---
 rtl/melody_sequencer_if.sv | 12 +
 rtl/melody_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer_if.sv
// Note ROM bus: the sequencer drives the address and the synchronous ROM
// returns the word one cycle later.
interface melody_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 40
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave (input rom_addr, output rom_data);
endinterface

// File: rtl/melody_sequencer.sv
// Multi-voice square-wave melody player with saturating mixer.
// Optional tempo change enabled by MELODY_SEQ_TEMPO_CHANGE_EN.
module melody_sequencer #(
    parameter int          NUM_VOICES = 2,
    parameter int          HP_W       = 20,
    parameter int          ADDR_W     = 10,
    parameter int          TEMPO_W    = 27,
    parameter logic [31:0] AMPLITUDE  = 32'd500000000
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                start,
    input  logic                enable,
    input  logic                loop_en,
    input  logic [ADDR_W-1:0]   song_last,
    input  logic [TEMPO_W-1:0]  tempo_limit,
    input  logic [TEMPO_W-1:0]  tempo_alt_limit,
    input  logic [ADDR_W-1:0]   tempo_change_addr,
    melody_sequencer_if.master  rom,
    output logic [31:0]         sample_out,
    output logic                playing,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY
    } state_t;

    localparam logic signed [33:0] AMP34 = {2'b00, AMPLITUDE};
    localparam logic signed [33:0] MAXV  = 34'sh0_7FFF_FFFF;
    localparam logic signed [33:0] MINV  = 34'sh3_8000_0000;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic [TEMPO_W-1:0] note_cnt;
    logic [TEMPO_W-1:0] limit_cur;
    logic               note_end;
    logic               last_note;
    logic               go;
    logic               adv;
    logic               wrap;
    logic               fin;

    logic [HP_W-1:0]    hp_q   [NUM_VOICES];
    logic [HP_W-1:0]    vcnt_q [NUM_VOICES];
    logic               ph_q   [NUM_VOICES];
    logic signed [33:0] mix_sum;
    logic [31:0]        mix_sat;

    assign rom.rom_addr = addr_q;

    assign go        = enable & start;
    assign note_end  = (state == S_PLAY) && (note_cnt == limit_cur);
    assign last_note = (addr_q == song_last);
    assign adv  = enable & ~start & note_end & ~last_note;
    assign wrap = enable & ~start & note_end & last_note & loop_en;
    assign fin  = enable & ~start & note_end & last_note & ~loop_en;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (go) begin
            state_nxt = S_FETCH;
        end else if (enable) begin
            unique case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_FETCH: state_nxt = S_LOAD;
                S_LOAD:  state_nxt = S_PLAY;
                S_PLAY: begin
                    if (adv || wrap) state_nxt = S_FETCH;
                    else if (fin)    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        playing = (state != S_IDLE);
    end

`ifdef MELODY_SEQ_TEMPO_CHANGE_EN
    logic alt_q;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            alt_q <= 1'b0;
        end else if (go || wrap) begin
            alt_q <= 1'b0;
        end else if (adv && addr_q == tempo_change_addr) begin
            alt_q <= 1'b1;
        end
    end

    assign limit_cur = alt_q ? tempo_alt_limit : tempo_limit;
`else
    logic unused_cfg;

    assign unused_cfg = ^{tempo_alt_limit, tempo_change_addr};
    assign limit_cur  = tempo_limit;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            addr_q   <= '0;
            note_cnt <= '0;
        end else if (enable) begin
            if (start || wrap) begin
                addr_q <= '0;
            end else if (adv) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (start || state == S_LOAD || note_end) begin
                note_cnt <= '0;
            end else if (state == S_PLAY) begin
                note_cnt <= note_cnt + TEMPO_W'(1);
            end
        end
    end

    // Voices free-run through FETCH on the old note; finishing a song mutes them.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                hp_q[v]   <= '0;
                vcnt_q[v] <= '0;
                ph_q[v]   <= 1'b0;
            end
        end else if (enable) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (fin) begin
                    hp_q[v]   <= '0;
                    vcnt_q[v] <= '0;
                    ph_q[v]   <= 1'b0;
                end else if (state == S_LOAD) begin
                    hp_q[v]   <= rom.rom_data[v*HP_W +: HP_W];
                    vcnt_q[v] <= '0;
                    ph_q[v]   <= 1'b1;
                end else if (state != S_IDLE && hp_q[v] != '0) begin
                    if (vcnt_q[v] == hp_q[v]) begin
                        vcnt_q[v] <= '0;
                        ph_q[v]   <= ~ph_q[v];
                    end else begin
                        vcnt_q[v] <= vcnt_q[v] + HP_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (hp_q[v] != '0) begin
                mix_sum = ph_q[v] ? mix_sum + AMP34 : mix_sum - AMP34;
            end
        end
        if (mix_sum > MAXV) begin
            mix_sat = 32'h7FFF_FFFF;
        end else if (mix_sum < MINV) begin
            mix_sat = 32'h8000_0000;
        end else begin
            mix_sat = mix_sum[31:0];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            sample_out <= '0;
            done       <= 1'b0;
        end else begin
            sample_out <= (enable && state != S_IDLE) ? mix_sat : 32'd0;
            done       <= fin;
        end
    end

endmodule
